br_stat_ctrl: RTL and testbench

- Windowed branch-prediction statistics controller sitting beside the fetch/branch-resolve stage.
- Consumes per-cycle branch-resolve events and sequences measurement windows (start/stop/clear).
- Snapshots per-window branch/correct counts into a single-entry valid/ready report slot and maintains saturating run totals.
- Replaces free-running print-based accounting with a controllable, backpressure-aware report stream for CSR readout or bench logging.

---
 rtl/br_stat_pkg.sv | 28 ++
 rtl/br_stat_win_cnt.sv | 47 ++++
 rtl/br_stat_ctrl.sv | 159 +++++++++++++++
 tb/tb_br_stat_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/br_stat_pkg.sv
// rtl/br_stat_pkg.sv - shared types, defaults and saturating helper for br_stat_ctrl
package br_stat_pkg;

   localparam int DEFAULT_WINDOW_P = 50;
   localparam int RPT_W            = 16;
   localparam int SAT_W            = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   // Report fields are RPT_W wide; the controller's WIN_W must not exceed RPT_W.
   typedef struct packed {
      logic [RPT_W-1:0] br;
      logic [RPT_W-1:0] correct;
      logic [15:0]      seq;
      logic             partial;
   } rpt_t;

   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int w);
      logic [SAT_W-1:0] lim;
      lim = {SAT_W{1'b1}} >> (SAT_W - w);
      return (v >= lim) ? v : v + SAT_W'(1);
   endfunction

endpackage

// File: rtl/br_stat_win_cnt.sv
// rtl/br_stat_win_cnt.sv - per-window branch/correct counter pair with completion detect
module br_stat_win_cnt #(
   parameter int WIN_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_inc_br,
   input  logic             i_inc_correct,
   input  logic [WIN_W-1:0] i_win_len,
   output logic [WIN_W-1:0] o_br,
   output logic [WIN_W-1:0] o_correct,
   output logic [WIN_W-1:0] o_br_nxt,
   output logic [WIN_W-1:0] o_correct_nxt,
   output logic             o_complete
);

   logic [WIN_W-1:0] r_br;
   logic [WIN_W-1:0] r_correct;
   logic [WIN_W-1:0] w_br_nxt;
   logic [WIN_W-1:0] w_correct_nxt;

   assign w_br_nxt      = r_br + WIN_W'(i_inc_br);
   assign w_correct_nxt = r_correct + WIN_W'(i_inc_correct);

   // Completion only on a counted branch, so an idle window never self-completes.
   assign o_complete    = i_inc_br & (w_br_nxt == i_win_len);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_br      <= '0;
         r_correct <= '0;
      end else if (i_clr) begin
         r_br      <= '0;
         r_correct <= '0;
      end else begin
         r_br      <= w_br_nxt;
         r_correct <= w_correct_nxt;
      end
   end

   assign o_br          = r_br;
   assign o_correct     = r_correct;
   assign o_br_nxt      = w_br_nxt;
   assign o_correct_nxt = w_correct_nxt;

endmodule

// File: rtl/br_stat_ctrl.sv
// rtl/br_stat_ctrl.sv - windowed branch-prediction statistics with single-entry report slot
module br_stat_ctrl import br_stat_pkg::*; #(
   parameter int CNT_W          = 32,
   parameter int WIN_W          = 16,
   parameter int DEFAULT_WINDOW = DEFAULT_WINDOW_P
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_stop,
   input  logic             i_clear,
   input  logic [WIN_W-1:0] i_window,
   input  logic             i_is_br,
   input  logic             i_is_correct,
   output logic             o_rpt_valid,
   input  logic             i_rpt_ready,
   output logic [WIN_W-1:0] o_rpt_br,
   output logic [WIN_W-1:0] o_rpt_correct,
   output logic [15:0]      o_rpt_seq,
   output logic             o_rpt_partial,
   output logic [CNT_W-1:0] o_total_br,
   output logic [CNT_W-1:0] o_total_correct,
   output logic [CNT_W-1:0] o_drop_cnt,
   output logic             o_busy
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIN_W-1:0] r_win_len;
   rpt_t             r_rpt;
   rpt_t             w_rpt_new;
   logic             r_rpt_valid;
   logic [15:0]      r_seq;
   logic [CNT_W-1:0] r_total_br;
   logic [CNT_W-1:0] r_total_correct;
   logic [CNT_W-1:0] r_drop_cnt;

   logic             w_inc_br;
   logic             w_inc_correct;
   logic             w_complete;
   logic             w_flush_go;
   logic             w_slot_busy;
   logic             w_load;
   logic             w_drop;
   logic             w_win_clr;
   logic [WIN_W-1:0] w_win_br;
   logic [WIN_W-1:0] w_win_correct;
   logic [WIN_W-1:0] w_br_nxt;
   logic [WIN_W-1:0] w_correct_nxt;

   assign w_inc_br      = (r_state == ST_RUN) & ~i_clear & i_is_br;
   assign w_inc_correct = w_inc_br & i_is_correct;
   assign w_flush_go    = (r_state == ST_FLUSH) & (~r_rpt_valid | i_rpt_ready);
   assign w_slot_busy   = r_rpt_valid & ~i_rpt_ready;
   // A flush waits for a free slot; only a completing window can be dropped.
   assign w_load        = (w_complete & ~w_slot_busy) | w_flush_go;
   assign w_drop        = w_complete & w_slot_busy;
   assign w_win_clr     = i_clear | w_complete | w_flush_go;

   br_stat_win_cnt #(
      .WIN_W(WIN_W)
   ) u_win_cnt (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_clr         (w_win_clr),
      .i_inc_br      (w_inc_br),
      .i_inc_correct (w_inc_correct),
      .i_win_len     (r_win_len),
      .o_br          (w_win_br),
      .o_correct     (w_win_correct),
      .o_br_nxt      (w_br_nxt),
      .o_correct_nxt (w_correct_nxt),
      .o_complete    (w_complete)
   );

   always_comb begin
      w_state_nxt = r_state;
      if (i_clear) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_RUN;
            ST_RUN: begin
               if (i_stop) begin
                  w_state_nxt = ((w_br_nxt != '0) && !w_complete) ? ST_FLUSH : ST_IDLE;
               end
            end
            ST_FLUSH: if (w_flush_go) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_rpt_new         = '0;
      w_rpt_new.br      = RPT_W'(w_complete ? r_win_len : w_win_br);
      w_rpt_new.correct = RPT_W'(w_complete ? w_correct_nxt : w_win_correct);
      w_rpt_new.seq     = r_seq;
      w_rpt_new.partial = ~w_complete;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_win_len <= WIN_W'(DEFAULT_WINDOW);
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_IDLE) && i_start && !i_clear) begin
            r_win_len <= (i_window == '0) ? WIN_W'(DEFAULT_WINDOW) : i_window;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rpt           <= '0;
         r_rpt_valid     <= 1'b0;
         r_seq           <= '0;
         r_total_br      <= '0;
         r_total_correct <= '0;
         r_drop_cnt      <= '0;
      end else if (i_clear) begin
         r_rpt           <= '0;
         r_rpt_valid     <= 1'b0;
         r_seq           <= '0;
         r_total_br      <= '0;
         r_total_correct <= '0;
         r_drop_cnt      <= '0;
      end else begin
         if (w_load) begin
            r_rpt       <= w_rpt_new;
            r_rpt_valid <= 1'b1;
            r_seq       <= r_seq + 16'd1;
         end else if (r_rpt_valid && i_rpt_ready) begin
            r_rpt_valid <= 1'b0;
         end
         if (w_drop) begin
            r_drop_cnt <= CNT_W'(sat_inc(SAT_W'(r_drop_cnt), CNT_W));
         end
         if (w_inc_br) begin
            r_total_br <= CNT_W'(sat_inc(SAT_W'(r_total_br), CNT_W));
         end
         if (w_inc_correct) begin
            r_total_correct <= CNT_W'(sat_inc(SAT_W'(r_total_correct), CNT_W));
         end
      end
   end

   assign o_rpt_valid     = r_rpt_valid;
   assign o_rpt_br        = r_rpt.br[WIN_W-1:0];
   assign o_rpt_correct   = r_rpt.correct[WIN_W-1:0];
   assign o_rpt_seq       = r_rpt.seq;
   assign o_rpt_partial   = r_rpt.partial;
   assign o_total_br      = r_total_br;
   assign o_total_correct = r_total_correct;
   assign o_drop_cnt      = r_drop_cnt;
   assign o_busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_br_stat_ctrl.sv
// tb/tb_br_stat_ctrl.sv - scoreboard bench for br_stat_ctrl with a behavioural window model
module tb_br_stat_ctrl;

   localparam int     WIN_W = 16;
   localparam int     CNT_A = 32;
   localparam int     CNT_B = 4;
   localparam longint CAP_A = 64'h0000_0000_FFFF_FFFF;
   localparam longint CAP_B = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic             start, stop, clear, is_br, is_cor, ready;
   logic [WIN_W-1:0] window;

   logic             a_valid, a_partial, a_busy;
   logic [WIN_W-1:0] a_br, a_cor;
   logic [15:0]      a_seq;
   logic [CNT_A-1:0] a_tbr, a_tcor, a_drop;

   logic             b_valid, b_partial, b_busy;
   logic [WIN_W-1:0] b_br, b_cor;
   logic [15:0]      b_seq;
   logic [CNT_B-1:0] b_tbr, b_tcor, b_drop;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int br;
      int cor;
      int seq;
      int partial;
   } exp_t;
   exp_t q[$];

   // Reference model state: mode 0 idle, 1 measuring, 2 flush pending.
   int     m_mode, m_win, m_cbr, m_ccor, m_seq;
   bit     m_valid;
   longint m_tbr, m_tcor, m_drop, m_tbr2, m_tcor2, m_drop2;

   always #5 clk = ~clk;

   br_stat_ctrl #(.CNT_W(CNT_A), .WIN_W(WIN_W), .DEFAULT_WINDOW(50)) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_clear(clear),
      .i_window(window), .i_is_br(is_br), .i_is_correct(is_cor),
      .o_rpt_valid(a_valid), .i_rpt_ready(ready), .o_rpt_br(a_br),
      .o_rpt_correct(a_cor), .o_rpt_seq(a_seq), .o_rpt_partial(a_partial),
      .o_total_br(a_tbr), .o_total_correct(a_tcor), .o_drop_cnt(a_drop), .o_busy(a_busy)
   );

   br_stat_ctrl #(.CNT_W(CNT_B), .WIN_W(WIN_W), .DEFAULT_WINDOW(50)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_clear(clear),
      .i_window(window), .i_is_br(is_br), .i_is_correct(is_cor),
      .o_rpt_valid(b_valid), .i_rpt_ready(ready), .o_rpt_br(b_br),
      .o_rpt_correct(b_cor), .o_rpt_seq(b_seq), .o_rpt_partial(b_partial),
      .o_total_br(b_tbr), .o_total_correct(b_tcor), .o_drop_cnt(b_drop), .o_busy(b_busy)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint sat(input longint v, input longint cap);
      return (v >= cap) ? v : v + 1;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_win = 50; m_cbr = 0; m_ccor = 0; m_seq = 0; m_valid = 0;
      m_tbr = 0; m_tcor = 0; m_drop = 0; m_tbr2 = 0; m_tcor2 = 0; m_drop2 = 0;
      q.delete();
   endtask

   task automatic model_edge();
      bit ld, cmp, part;
      int lb, lc;
      ld = 0; cmp = 0; part = 0; lb = 0; lc = 0;
      if (clear) begin
         m_mode = 0; m_cbr = 0; m_ccor = 0; m_seq = 0; m_valid = 0;
         m_tbr = 0; m_tcor = 0; m_drop = 0; m_tbr2 = 0; m_tcor2 = 0; m_drop2 = 0;
         q.delete();
         return;
      end
      case (m_mode)
         0: if (start) begin
            m_win  = (window == 0) ? 50 : int'(window);
            m_mode = 1;
         end
         1: begin
            if (is_br) begin
               m_cbr++;
               m_tbr  = sat(m_tbr, CAP_A);
               m_tbr2 = sat(m_tbr2, CAP_B);
               if (is_cor) begin
                  m_ccor++;
                  m_tcor  = sat(m_tcor, CAP_A);
                  m_tcor2 = sat(m_tcor2, CAP_B);
               end
               if (m_cbr == m_win) begin
                  ld = 1; cmp = 1; lb = m_cbr; lc = m_ccor;
                  m_cbr = 0; m_ccor = 0;
               end
            end
            if (stop) m_mode = (m_cbr > 0) ? 2 : 0;
         end
         default: if (!m_valid || ready) begin
            ld = 1; part = 1; lb = m_cbr; lc = m_ccor;
            m_cbr = 0; m_ccor = 0; m_mode = 0;
         end
      endcase
      if (ld) begin
         if (cmp && m_valid && !ready) begin
            m_drop  = sat(m_drop, CAP_A);
            m_drop2 = sat(m_drop2, CAP_B);
         end else begin
            m_valid = 1;
            q.push_back('{br: lb, cor: lc, seq: m_seq, partial: int'(part)});
            m_seq = (m_seq + 1) % 65536;
         end
      end else if (m_valid && ready) begin
         m_valid = 0;
      end
   endtask

   task automatic check_outputs();
      chk("rpt_valid", a_valid, m_valid);
      chk("busy", a_busy, (m_mode != 0));
      chk("total_br", a_tbr, m_tbr);
      chk("total_correct", a_tcor, m_tcor);
      chk("drop_cnt", a_drop, m_drop);
      chk("sat_total_br", b_tbr, m_tbr2);
      chk("sat_total_correct", b_tcor, m_tcor2);
      chk("sat_drop_cnt", b_drop, m_drop2);
   endtask

   task automatic step(input bit s, input bit p, input bit c, input int w,
                       input bit b, input bit cr, input bit rdy);
      start = s; stop = p; clear = c; window = WIN_W'(w);
      is_br = b; is_cor = cr; ready = rdy;
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("rst_valid", a_valid, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_total_br", a_tbr, 0);
      chk("rst_total_correct", a_tcor, 0);
      chk("rst_drop", a_drop, 0);
      chk("rst_seq", a_seq, 0);
      chk("rst_rpt_br", a_br, 0);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Scoreboard monitor: every accepted report must match the oldest expected one.
   always @(negedge clk) begin
      if (!rst && a_valid && ready) begin
         if (q.size() == 0) begin
            chk("rpt_unexpected", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("rpt_br", a_br, e.br);
            chk("rpt_correct", a_cor, e.cor);
            chk("rpt_seq", a_seq, e.seq);
            chk("rpt_partial", a_partial, e.partial);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; start = 0; stop = 0; clear = 0; window = '0;
      is_br = 0; is_cor = 0; ready = 0;
      model_reset();
      #1;
      async_reset();
      step(0, 0, 0, 0, 0, 0, 1);

      // Window of 4, consumer always ready; a branch in the start cycle is ignored.
      step(1, 0, 0, 4, 1, 1, 1);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 4, 1, (i != 2), 1);
      step(0, 0, 0, 4, 0, 0, 1);
      step(0, 0, 0, 4, 0, 0, 1);

      // Backpressure: second completing window is dropped, first report held.
      for (int i = 0; i < 8; i++) step(0, 0, 0, 4, 1, i[0], 0);
      step(0, 0, 0, 4, 0, 0, 0);
      step(0, 0, 0, 4, 0, 0, 1);
      step(0, 0, 0, 4, 0, 0, 0);

      // Stop mid-window while a report is pending.
      for (int i = 0; i < 4; i++) step(0, 0, 0, 4, 1, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 4, 1, i[0], 0);
      step(0, 1, 0, 4, 0, 0, 0);
      step(0, 0, 0, 4, 0, 0, 0);
      step(0, 0, 0, 4, 0, 0, 0);
      step(0, 0, 0, 4, 0, 0, 1);
      step(0, 0, 0, 4, 0, 0, 1);
      step(0, 0, 0, 4, 0, 0, 1);

      // Default window of 50, alternating outcome; 51st branch opens a new window.
      step(1, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 51; i++) step(0, 0, 0, 0, 1, (i % 2 == 0), 1);
      step(0, 1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);

      // Async reset mid-run; later branches without start are not counted.
      step(1, 0, 0, 5, 0, 0, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 5, 1, 1, 1);
      async_reset();
      for (int i = 0; i < 4; i++) step(0, 0, 0, 5, 1, 1, 1);

      // Saturation on the narrow instance: window 100, 20 branches.
      step(1, 0, 0, 100, 0, 0, 1);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 100, 1, 1, 1);
      step(0, 0, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         int w;
         w = ($urandom % 10 == 0) ? 100 : int'($urandom % 9);
         step(($urandom % 16) == 0, ($urandom % 24) == 0, ($urandom % 200) == 0, w,
              ($urandom % 4) != 0, $urandom % 2, ($urandom % 5) < 3);
      end

      step(0, 0, 1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      chk("final_queue_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
